// File: rtl/rx_word_buffer.sv
// Receive-side FIFO behind the TRX receiver: buffers decoded words with their ECC flags,
// back-pressures the receiver and keeps saturating error statistics.
module rx_word_buffer #(
  parameter int unsigned DATA_W       = 4,
  parameter int unsigned DEPTH        = 8,
  parameter int unsigned AFULL_MARGIN = 2,
  parameter bit          DROP_UNCORR  = 1'b1,
  parameter int unsigned CNT_W        = 8,
  localparam int unsigned PtrW        = $clog2(DEPTH),
  localparam int unsigned LvlW        = PtrW + 1
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_err_cor,
  input  logic              in_err_unc,
  output logic              rx_not_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_err_cor,
  output logic              out_err_unc,
  input  logic              out_ready,
  output logic [LvlW-1:0]   level,
  input  logic              clr_cnt,
  output logic [CNT_W-1:0]  cnt_words,
  output logic [CNT_W-1:0]  cnt_cor,
  output logic [CNT_W-1:0]  cnt_unc,
  output logic [CNT_W-1:0]  cnt_drop
);

  if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("rx_word_buffer: DEPTH must be a power of 2 and >= 4");
  end
  if (AFULL_MARGIN < 1 || AFULL_MARGIN > DEPTH - 1) begin : g_bad_margin
    $error("rx_word_buffer: AFULL_MARGIN must be in 1..DEPTH-1");
  end
  if (DATA_W < 1 || CNT_W < 1) begin : g_bad_width
    $error("rx_word_buffer: DATA_W and CNT_W must be >= 1");
  end

  localparam int unsigned EntW = DATA_W + 2;

  logic [EntW-1:0]   mem_q [DEPTH];
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [LvlW-1:0]   level_q, level_d;
  logic              not_ready_q, not_ready_d;
  logic [CNT_W-1:0]  cnt_words_q, cnt_words_d;
  logic [CNT_W-1:0]  cnt_cor_q, cnt_cor_d;
  logic [CNT_W-1:0]  cnt_unc_q, cnt_unc_d;
  logic [CNT_W-1:0]  cnt_drop_q, cnt_drop_d;
  logic              rd_en, wr_en, drop;
  logic [EntW-1:0]   head;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
    return (en && v != '1) ? v + CNT_W'(1) : v;
  endfunction

  always_comb begin
    rd_en       = out_valid & out_ready;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the word.
    wr_en       = in_valid && !(DROP_UNCORR && in_err_unc) &&
                  (level_q < LvlW'(DEPTH) || rd_en);
    drop        = in_valid & ~wr_en;
    wr_ptr_d    = wr_en ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
    rd_ptr_d    = rd_en ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
    level_d     = level_q + LvlW'(wr_en) - LvlW'(rd_en);
    not_ready_d = level_d >= LvlW'(DEPTH - AFULL_MARGIN);
    if (clr_cnt) begin
      cnt_words_d = '0;
      cnt_cor_d   = '0;
      cnt_unc_d   = '0;
      cnt_drop_d  = '0;
    end else begin
      cnt_words_d = sat_inc(cnt_words_q, wr_en);
      cnt_cor_d   = sat_inc(cnt_cor_q, in_valid & in_err_cor);
      cnt_unc_d   = sat_inc(cnt_unc_q, in_valid & in_err_unc);
      cnt_drop_d  = sat_inc(cnt_drop_q, drop);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      not_ready_q <= 1'b0;
      cnt_words_q <= '0;
      cnt_cor_q   <= '0;
      cnt_unc_q   <= '0;
      cnt_drop_q  <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      not_ready_q <= not_ready_d;
      cnt_words_q <= cnt_words_d;
      cnt_cor_q   <= cnt_cor_d;
      cnt_unc_q   <= cnt_unc_d;
      cnt_drop_q  <= cnt_drop_d;
    end
  end

  // Storage needs no reset: entries are only observed while counted in level_q.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= {in_err_unc, in_err_cor, in_data};
    end
  end

  always_comb begin
    out_valid    = level_q != '0;
    head         = out_valid ? mem_q[rd_ptr_q] : '0;
    out_data     = head[DATA_W-1:0];
    out_err_cor  = head[DATA_W];
    out_err_unc  = head[DATA_W+1];
    rx_not_ready = not_ready_q;
    level        = level_q;
    cnt_words    = cnt_words_q;
    cnt_cor      = cnt_cor_q;
    cnt_unc      = cnt_unc_q;
    cnt_drop     = cnt_drop_q;
  end

endmodule
